// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: state encoding, counter width, default bit period.
// The state encoding is the 3-bit set shared with uart_tx.
package uart_rx_pkg;

   localparam int CLKS_PER_BIT_DEF = 3603;
   localparam int CNT_W            = 12;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
      S_PARITY  = 3'd3,
      S_STOP    = 3'd4,
      S_CLEANUP = 3'd5
   } uart_state_e;

   // Count at which the start bit is re-checked: the middle of the start bit.
   function automatic int half_bit(input int cpb);
      return (cpb - 1) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line and received-byte outputs of the UART receiver.
// slave = receiver side, master = line driver / byte consumer.
interface uart_rx_if;
   logic       i_Rx_Serial;
   logic       o_Rx_DV;
   logic [7:0] o_Rx_Byte;
   logic       o_Rx_Active;
   logic       o_Rx_Frame_Err;
   logic       o_Rx_Parity_Err;
   logic [2:0] o_Rx_State;

   // Strobes (DV, Frame_Err, Parity_Err) are single-cycle, mutually exclusive and
   // carry no back-pressure: the consumer must take o_Rx_Byte in the DV cycle or
   // before the next good byte overwrites it.
   modport slave (
      input  i_Rx_Serial,
      output o_Rx_DV, o_Rx_Byte, o_Rx_Active, o_Rx_Frame_Err, o_Rx_Parity_Err, o_Rx_State
   );

   modport master (
      output i_Rx_Serial,
      input  o_Rx_DV, o_Rx_Byte, o_Rx_Active, o_Rx_Frame_Err, o_Rx_Parity_Err, o_Rx_State
   );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Reset value is a parameter so idle-high lines come out of reset inactive.
module uart_rx_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_Async,
   output logic o_Sync
);

   logic meta_q, sync_q;
   logic meta_d, sync_d;

   always_comb begin
      meta_d = i_Async;
      sync_d = meta_q;
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign o_Sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames sampled at mid-bit, one-cycle strobes for good byte / framing error.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop (8E1).
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic     i_Clock,
   input  logic     i_Reset,
   uart_rx_if.slave rx_if
);

   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(half_bit(CLKS_PER_BIT));
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic rx_s;

   uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .i_Async (rx_if.i_Rx_Serial),
      .o_Sync  (rx_s)
   );

   uart_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       byte_q, byte_d;
   logic             active_q, active_d;
   logic             dv_q, dv_d;
   logic             ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic             par_bad_q, par_bad_d;
   logic             perr_q, perr_d;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      byte_d   = byte_q;
      active_d = active_q;
      dv_d     = 1'b0;
      ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
      perr_d    = 1'b0;
`endif
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
            if (!rx_s) begin
               state_d  = S_START;
               active_d = 1'b1;
            end
         end
         S_START: begin
            if (cnt_q == HALF_CNT) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d = S_DATA;
               end else begin
                  // Low pulse shorter than half a bit: treat as noise.
                  state_d  = S_IDLE;
                  active_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == FULL_CNT) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s;
               if (idx_q == 3'd7) begin
                  idx_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == FULL_CNT) begin
               cnt_d     = '0;
               par_bad_d = (^shift_q) ^ rx_s;
               state_d   = S_STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif
         S_STOP: begin
            if (cnt_q == FULL_CNT) begin
               cnt_d   = '0;
               state_d = S_CLEANUP;
               if (!rx_s) begin
                  ferr_d = 1'b1;
               end else begin
`ifdef UART_RX_PARITY_EN
                  if (par_bad_q) begin
                     perr_d = 1'b1;
                  end else begin
                     byte_d = shift_q;
                     dv_d   = 1'b1;
                  end
`else
                  byte_d = shift_q;
                  dv_d   = 1'b1;
`endif
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_CLEANUP: begin
            // A line held low (break) must go high before the next start bit is armed.
            if (rx_s) begin
               state_d  = S_IDLE;
               active_d = 1'b0;
            end
         end
         default: begin
            state_d  = S_IDLE;
            active_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         byte_q   <= '0;
         active_q <= 1'b0;
         dv_q     <= 1'b0;
         ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         byte_q   <= byte_d;
         active_q <= active_d;
         dv_q     <= dv_d;
         ferr_q   <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= par_bad_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign rx_if.o_Rx_DV        = dv_q;
   assign rx_if.o_Rx_Byte      = byte_q;
   assign rx_if.o_Rx_Active    = active_q;
   assign rx_if.o_Rx_Frame_Err = ferr_q;
   assign rx_if.o_Rx_State     = state_q;
`ifdef UART_RX_PARITY_EN
   assign rx_if.o_Rx_Parity_Err = perr_q;
`else
   assign rx_if.o_Rx_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at CLKS_PER_BIT=16: vector table, hand-written corner sequences,
// then random frames scored against a frame-level reference model.
module tb_uart_rx;
   import uart_rx_pkg::*;

   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam int DV_LAT = 2 + (CPB - 1) / 2 + 9 * CPB + 1 + (PAR_EN ? CPB : 0);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_rx_if rx_if ();

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clock (clk),
      .i_Reset (rst),
      .rx_if   (rx_if)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- bookkeeping ----------------
   int total = 0;
   int bad   = 0;
   int dv_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
   int last_dv_cyc = 0;
   int fall_cyc = 0;
   bit scb_en = 1'b0;
   logic prev_strobe = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] model_byte = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      int n;
      n = rx_if.o_Rx_DV + rx_if.o_Rx_Frame_Err + rx_if.o_Rx_Parity_Err;
      if (rx_if.o_Rx_DV) begin
         dv_cnt++;
         last_dv_cyc = cyc;
         if (scb_en) begin
            if (exp_q.size() == 0) check("scb_unexpected_dv", 32'(rx_if.o_Rx_Byte), 32'hFFFF);
            else check("scb_byte", 32'(rx_if.o_Rx_Byte), 32'(exp_q.pop_front()));
         end
      end
      if (rx_if.o_Rx_Frame_Err) ferr_cnt++;
      if (rx_if.o_Rx_Parity_Err) perr_cnt++;
      if (n != 0) begin
         check("strobe_exclusive", n, 1);
         check("strobe_one_cycle", 32'(prev_strobe), 0);
      end
      prev_strobe = (n != 0);
   end

   // ---------------- driver tasks ----------------
   task automatic hold(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      rx_if.i_Rx_Serial = 1'b0;
      fall_cyc = cyc;
      hold(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_if.i_Rx_Serial = d[i];
         hold(CPB);
      end
      if (PAR_EN) begin
         rx_if.i_Rx_Serial = par;
         hold(CPB);
      end
      rx_if.i_Rx_Serial = stop;
      hold(CPB);
   endtask

   // Reference: 0 = good byte, 1 = framing error, 2 = parity error.
   function automatic int frame_outcome(input logic [7:0] d, input logic par, input logic stop);
      if (!stop) return 1;
      if (PAR_EN && (((^d) ^ par) != 1'b0)) return 2;
      return 0;
   endfunction

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      int         low_bits;
      int         gap;
      int         exp_dv;
      int         exp_ferr;
      int         exp_perr;
      logic [7:0] exp_byte;
   } vec_t;

   vec_t vecs[$];

   initial begin
      vec_t v;
      int dv0, fe0, pe0, lat, oc;
      logic [7:0] d;
      logic p, s;
      int lowb, gap;

      v = '{8'h55, 1'b0, 1'b1, 0, CPB, 1, 0, 0, 8'h55}; vecs.push_back(v);
      v = '{8'hA3, 1'b0, 1'b0, 3, CPB, 0, 1, 0, 8'h55}; vecs.push_back(v);
      v = '{8'h00, 1'b0, 1'b1, 0, 0,   1, 0, 0, 8'h00}; vecs.push_back(v);
      v = '{8'hFF, 1'b0, 1'b1, 0, CPB, 1, 0, 0, 8'hFF}; vecs.push_back(v);
`ifdef UART_RX_PARITY_EN
      v = '{8'h07, 1'b1, 1'b1, 0, CPB, 1, 0, 0, 8'h07}; vecs.push_back(v);
      v = '{8'h07, 1'b0, 1'b1, 0, CPB, 0, 0, 1, 8'h07}; vecs.push_back(v);
`endif

      // reset state
      rst = 1'b1;
      rx_if.i_Rx_Serial = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dv",     32'(rx_if.o_Rx_DV), 0);
      check("rst_byte",   32'(rx_if.o_Rx_Byte), 0);
      check("rst_active", 32'(rx_if.o_Rx_Active), 0);
      check("rst_ferr",   32'(rx_if.o_Rx_Frame_Err), 0);
      check("rst_perr",   32'(rx_if.o_Rx_Parity_Err), 0);
      check("rst_state",  32'(rx_if.o_Rx_State), 32'(S_IDLE));
      rst = 1'b0;
      hold(4);

      // vector table
      foreach (vecs[i]) begin
         dv0 = dv_cnt; fe0 = ferr_cnt; pe0 = perr_cnt;
         send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
         check($sformatf("vec%0d_dv", i),   dv_cnt - dv0,   vecs[i].exp_dv);
         check($sformatf("vec%0d_ferr", i), ferr_cnt - fe0, vecs[i].exp_ferr);
         check($sformatf("vec%0d_perr", i), perr_cnt - pe0, vecs[i].exp_perr);
         check($sformatf("vec%0d_byte", i), 32'(rx_if.o_Rx_Byte), 32'(vecs[i].exp_byte));
         if (vecs[i].exp_dv != 0) begin
            lat = last_dv_cyc - fall_cyc;
            total++;
            if (lat < DV_LAT - 1 || lat > DV_LAT + 1) begin
               bad++;
               $display("FAIL vec%0d_dv_latency: got %0d expected %0d+-1", i, lat, DV_LAT);
            end
         end
         if (vecs[i].low_bits > 0) begin
            rx_if.i_Rx_Serial = 1'b0;
            hold(vecs[i].low_bits * CPB);
            check($sformatf("vec%0d_break_state", i), 32'(rx_if.o_Rx_State), 32'(S_CLEANUP));
            check($sformatf("vec%0d_break_active", i), 32'(rx_if.o_Rx_Active), 1);
            check($sformatf("vec%0d_break_ferr", i), ferr_cnt - fe0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_break_dv", i), dv_cnt - dv0, 0);
         end
         rx_if.i_Rx_Serial = 1'b1;
         hold(vecs[i].gap);
      end
      model_byte = vecs[vecs.size() - 1].exp_byte;

      // start-bit glitch: 4 cycles low
      dv0 = dv_cnt; fe0 = ferr_cnt; pe0 = perr_cnt;
      rx_if.i_Rx_Serial = 1'b0;
      hold(4);
      rx_if.i_Rx_Serial = 1'b1;
      check("glitch_active_rise", 32'(rx_if.o_Rx_Active), 1);
      hold(3 * CPB);
      check("glitch_active_fall", 32'(rx_if.o_Rx_Active), 0);
      check("glitch_state", 32'(rx_if.o_Rx_State), 32'(S_IDLE));
      check("glitch_strobes", (dv_cnt - dv0) + (ferr_cnt - fe0) + (perr_cnt - pe0), 0);
      check("glitch_byte", 32'(rx_if.o_Rx_Byte), 32'(model_byte));

      // reset during data bit 4, then a clean frame
      d = 8'h96;
      rx_if.i_Rx_Serial = 1'b0;
      hold(CPB);
      for (int i = 0; i < 4; i++) begin
         rx_if.i_Rx_Serial = d[i];
         hold(CPB);
      end
      rx_if.i_Rx_Serial = d[4];
      hold(CPB / 2);
      check("midrst_active_before", 32'(rx_if.o_Rx_Active), 1);
      rst = 1'b1;
      rx_if.i_Rx_Serial = 1'b1;
      #1;
      check("midrst_byte",   32'(rx_if.o_Rx_Byte), 0);
      check("midrst_active", 32'(rx_if.o_Rx_Active), 0);
      check("midrst_dv",     32'(rx_if.o_Rx_DV), 0);
      check("midrst_state",  32'(rx_if.o_Rx_State), 32'(S_IDLE));
      hold(3);
      rst = 1'b0;
      hold(2 * CPB);
      model_byte = 8'h00;
      check("midrst_quiet_byte", 32'(rx_if.o_Rx_Byte), 32'(model_byte));
      dv0 = dv_cnt;
      send_frame(8'h3C, 1'b0, 1'b1);
      check("postrst_dv", dv_cnt - dv0, 1);
      check("postrst_byte", 32'(rx_if.o_Rx_Byte), 32'h3C);
      model_byte = 8'h3C;
      rx_if.i_Rx_Serial = 1'b1;
      hold(CPB);

      // random frames against the reference model
      scb_en = 1'b1;
      for (int k = 0; k < 16; k++) begin
         d = 8'($urandom_range(0, 255));
         p = 1'($urandom_range(0, 1));
         s = ($urandom_range(0, 3) != 0);
         oc = frame_outcome(d, p, s);
         if (oc == 0) begin
            exp_q.push_back(d);
            model_byte = d;
         end
         lowb = s ? 0 : $urandom_range(0, 2);
         gap  = s ? $urandom_range(0, CPB) : $urandom_range(CPB, 2 * CPB);
         fe0 = ferr_cnt; pe0 = perr_cnt;
         send_frame(d, p, s);
         check($sformatf("rnd%0d_ferr", k), ferr_cnt - fe0, (oc == 1) ? 1 : 0);
         check($sformatf("rnd%0d_perr", k), perr_cnt - pe0, (oc == 2) ? 1 : 0);
         check($sformatf("rnd%0d_byte", k), 32'(rx_if.o_Rx_Byte), 32'(model_byte));
         if (lowb > 0) begin
            rx_if.i_Rx_Serial = 1'b0;
            hold(lowb * CPB);
         end
         rx_if.i_Rx_Serial = 1'b1;
         hold(gap);
      end
      hold(2 * CPB);
      check("scb_drained", exp_q.size(), 0);
      scb_en = 1'b0;

      // final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
